// File: rtl/noc_pkg.sv
// Shared types for the NoC input buffer: flit type encoding, framing
// states and a helper that decodes the type field of a flit.
package noc_pkg;

  localparam int FLIT_W_DEF = 34;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    FS_IDLE   = 1'b0,
    FS_IN_PKT = 1'b1
  } frame_state_e;

  // Caller passes the two type bits (flit[FLIT_W-1:FLIT_W-2]) so the
  // helper stays independent of the flit width.
  function automatic flit_type_e flit_type(input logic [1:0] type_bits);
    return flit_type_e'(type_bits);
  endfunction

endpackage

// File: rtl/noc_input_buffer_if.sv
// Upstream link, switch-side handshake and status signals of one
// NoC router input port, bundled with slave (buffer) / master modports.
interface noc_input_buffer_if #(
  parameter int FLIT_W = noc_pkg::FLIT_W_DEF,
  parameter int DEPTH  = 4
);
  logic                     in_valid;
  logic [FLIT_W-1:0]        in_flit;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_ready;
  logic                     credit_out;
  logic [$clog2(DEPTH):0]   occupancy;
  logic                     overflow_err;
  logic                     proto_err;

  modport slave (
    input  in_valid, in_flit, out_ready,
    output out_valid, out_flit, credit_out, occupancy, overflow_err, proto_err
  );

  modport master (
    output in_valid, in_flit, out_ready,
    input  out_valid, out_flit, credit_out, occupancy, overflow_err, proto_err
  );
endinterface

// File: rtl/noc_flit_fifo.sv
// In-order flit storage with wrap-around pointers one bit wider than the
// address; the extra MSB separates full from empty.
module noc_flit_fifo #(
  parameter int FLIT_W = 34,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [FLIT_W-1:0]       push_data,
  input  logic                    pop,
  output logic [FLIT_W-1:0]       head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer advance; reset flushes every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occupancy = wr_ptr - rd_ptr;
endmodule

// File: rtl/noc_input_buffer.sv
// Credit-flow-controlled input buffer for one NoC router port: FIFO,
// framing checker, credit return and sticky error flags.
// Optional zero-latency bypass when empty: define NOC_BUF_BYPASS_EN.
//
// state     | meaning
// S_IDLE    | between packets; expects HEAD or SINGLE
// S_IN_PKT  | inside a packet; expects BODY or TAIL
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  noc_input_buffer_if.slave bus
);
  localparam logic [0:0] S_IDLE   = FS_IDLE;
  localparam logic [0:0] S_IN_PKT = FS_IN_PKT;

  logic [FLIT_W-1:0]       fifo_head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [$clog2(DEPTH):0]  fifo_occ;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    pop_any;
  logic                    drop;
  logic                    credit_q;
  logic                    ovf_q;
  logic                    perr_q;
  logic [0:0]              state;
  logic [0:0]              state_nxt;
  logic                    violation;
  flit_type_e              ftype;

`ifdef NOC_BUF_BYPASS_EN
  // An empty FIFO forwards the incoming flit straight to the switch; if it
  // is taken in the same cycle it never occupies a slot.
  assign bus.out_valid = fifo_empty ? bus.in_valid : 1'b1;
  assign bus.out_flit  = fifo_empty ? (bus.in_valid ? bus.in_flit : '0) : fifo_head;
  assign pop_any       = bus.out_valid && bus.out_ready;
  assign fifo_pop      = pop_any && !fifo_empty;
  assign fifo_push     = bus.in_valid && (!fifo_full || fifo_pop) &&
                         !(fifo_empty && bus.out_ready);
`else
  assign bus.out_valid = !fifo_empty;
  assign bus.out_flit  = fifo_empty ? '0 : fifo_head;
  assign pop_any       = bus.out_valid && bus.out_ready;
  assign fifo_pop      = pop_any;
  assign fifo_push     = bus.in_valid && (!fifo_full || fifo_pop);
`endif

  assign drop = bus.in_valid && fifo_full && !fifo_pop;

  noc_flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus.in_flit),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (fifo_occ)
  );

  assign ftype = flit_type(bus.in_flit[FLIT_W-1:FLIT_W-2]);

  // Framing check on every arriving flit, stored or dropped.
  always_comb begin
    state_nxt = state;
    violation = 1'b0;
    if (bus.in_valid) begin
      case (state)
        S_IDLE: begin
          if (ftype == FT_HEAD)        state_nxt = S_IN_PKT;
          else if (ftype != FT_SINGLE) violation = 1'b1;
        end
        default: begin
          if (ftype == FT_TAIL)        state_nxt = S_IDLE;
          else if (ftype != FT_BODY)   violation = 1'b1;
        end
      endcase
    end
  end

  // Framing state, registered credit pulse and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit_q <= pop_any;
      if (drop)      ovf_q  <= 1'b1;
      if (violation) perr_q <= 1'b1;
    end
  end

  assign bus.credit_out   = credit_q;
  assign bus.occupancy    = fifo_occ;
  assign bus.overflow_err = ovf_q;
  assign bus.proto_err    = perr_q;
endmodule

// File: tb/tb_noc_input_buffer.sv
// Bench for noc_input_buffer (default build): directed scenarios with
// literal expectations plus a random phase, all checked every cycle
// against a queue-based model of the buffer.
module tb_noc_input_buffer;
  localparam int FW = 34;
  localparam int DP = 4;
  localparam logic [1:0] T_BODY = 2'b00, T_TAIL = 2'b01, T_HEAD = 2'b10, T_SINGLE = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  noc_input_buffer_if #(.FLIT_W(FW), .DEPTH(DP)) bus ();

  noc_input_buffer #(.FLIT_W(FW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: the buffer is just an ordered list of at most DP flits.
  logic [FW-1:0] q[$];
  bit m_credit, m_ovf, m_perr, m_inpkt;
  int m_sz;
  bit m_pop, m_push;
  logic [1:0] m_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_credit = 0; m_ovf = 0; m_perr = 0; m_inpkt = 0;
    end else begin
      m_sz   = q.size();
      m_pop  = (m_sz > 0) && bus.out_ready;
      m_push = bus.in_valid && ((m_sz < DP) || m_pop);
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(bus.in_flit);
      if (bus.in_valid && m_sz == DP && !m_pop) m_ovf = 1;
      m_credit = m_pop;
      if (bus.in_valid) begin
        m_t = bus.in_flit[FW-1:FW-2];
        if (!m_inpkt) begin
          if (m_t == T_HEAD) m_inpkt = 1;
          else if (m_t != T_SINGLE) m_perr = 1;
        end else begin
          if (m_t == T_TAIL) m_inpkt = 0;
          else if (m_t != T_BODY) m_perr = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model midway through every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("m_out_flit", 64'(bus.out_flit), (q.size() > 0) ? 64'(q[0]) : 64'd0);
      chk("m_occupancy", 64'(bus.occupancy), 64'(q.size()));
      chk("m_credit", 64'(bus.credit_out), 64'(m_credit));
      chk("m_overflow", 64'(bus.overflow_err), 64'(m_ovf));
      chk("m_proto", 64'(bus.proto_err), 64'(m_perr));
    end
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  task automatic cyc(input logic v, input logic [FW-1:0] f, input logic r);
    bus.in_valid  = v;
    bus.in_flit   = f;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [FW-1:0] pk[4];
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_flit = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_flit", 64'(bus.out_flit), 64'd0);
    chk("rst_credit", 64'(bus.credit_out), 64'd0);
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_ovf", 64'(bus.overflow_err), 64'd0);
    chk("rst_perr", 64'(bus.proto_err), 64'd0);
    rst_n = 1'b1;
    cyc(0, '0, 0);

    // Single flit, one-cycle latency, one credit
    cyc(1, mk(T_SINGLE, 32'h0000_00AA), 0);
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_flit", 64'(bus.out_flit), 64'h3_0000_00AA);
    chk("single_occ", 64'(bus.occupancy), 64'd1);
    chk("single_credit0", 64'(bus.credit_out), 64'd0);
    cyc(0, '0, 1);
    chk("single_credit1", 64'(bus.credit_out), 64'd1);
    chk("single_occ0", 64'(bus.occupancy), 64'd0);
    cyc(0, '0, 0);
    chk("single_credit_end", 64'(bus.credit_out), 64'd0);

    // Four-flit packet, then drain in order
    pk[0] = mk(T_HEAD, 32'h1111_0001); pk[1] = mk(T_BODY, 32'h2222_0002);
    pk[2] = mk(T_BODY, 32'h3333_0003); pk[3] = mk(T_TAIL, 32'h4444_0004);
    for (int i = 0; i < 4; i++) cyc(1, pk[i], 0);
    chk("pkt_occ4", 64'(bus.occupancy), 64'd4);
    cyc(0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pkt_order", 64'(bus.out_flit), 64'(pk[i]));
      cyc(0, '0, 1);
      chk("pkt_credit", 64'(bus.credit_out), 64'd1);
    end
    chk("pkt_occ0", 64'(bus.occupancy), 64'd0);
    chk("pkt_perr", 64'(bus.proto_err), 64'd0);

    // Full FIFO: push with simultaneous pop is accepted, push without is dropped
    cyc(1, mk(T_HEAD, 32'hA0), 0);
    for (int i = 1; i < 4; i++) cyc(1, mk(T_BODY, 32'hA0 + i), 0);
    chk("full_occ", 64'(bus.occupancy), 64'd4);
    cyc(1, mk(T_BODY, 32'hA4), 1);
    chk("full_pushpop_occ", 64'(bus.occupancy), 64'd4);
    chk("full_pushpop_ovf", 64'(bus.overflow_err), 64'd0);
    cyc(1, mk(T_TAIL, 32'hA5), 0);
    chk("drop_ovf", 64'(bus.overflow_err), 64'd1);
    chk("drop_occ", 64'(bus.occupancy), 64'd4);
    chk("drop_head", 64'(bus.out_flit), 64'(mk(T_BODY, 32'hA1)));
    for (int i = 0; i < 4; i++) cyc(0, '0, 1);
    chk("drop_drained", 64'(bus.occupancy), 64'd0);

    // Framing violation: BODY while idle is flagged but stored
    cyc(1, mk(T_BODY, 32'hB0D1), 0);
    chk("perr_set", 64'(bus.proto_err), 64'd1);
    chk("perr_stored", 64'(bus.out_flit), 64'(mk(T_BODY, 32'hB0D1)));
    cyc(0, '0, 1);
    chk("perr_popped", 64'(bus.credit_out), 64'd1);

    // Streaming: push and pop every cycle across pointer wrap
    cyc(1, mk(T_SINGLE, 32'hC00), 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1, mk(T_SINGLE, 32'hC00 + i), 1);
      chk("stream_occ", 64'(bus.occupancy), 64'd1);
      chk("stream_flit", 64'(bus.out_flit), 64'(mk(T_SINGLE, 32'hC00 + i)));
    end
    cyc(0, '0, 1);
    cyc(0, '0, 0);

    // Reset mid-packet flushes everything at once
    cyc(1, mk(T_HEAD, 32'hD0), 0);
    cyc(1, mk(T_BODY, 32'hD1), 0);
    cyc(1, mk(T_BODY, 32'hD2), 0);
    chk("mid_occ3", 64'(bus.occupancy), 64'd3);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("mid_rst_perr", 64'(bus.proto_err), 64'd0);
    cyc(0, '0, 1);
    chk("mid_rst_credit", 64'(bus.credit_out), 64'd0);
    cyc(0, '0, 1);
    rst_n = 1'b1;
    cyc(0, '0, 1);
    chk("post_rst_credit", 64'(bus.credit_out), 64'd0);
    cyc(1, mk(T_TAIL, 32'hE0), 0);
    chk("post_rst_idle", 64'(bus.proto_err), 64'd1);
    cyc(0, '0, 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
          mk(2'($urandom_range(0, 3)), $urandom),
          ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0);
    end
    cyc(0, '0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
